// File: rtl/alu_stage_pkg.sv
// Shared constants, FSM encoding and instruction decode
// for the ALU operand/writeback stage.
package alu_stage_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  localparam int RS_HI = 25;
  localparam int RS_LO = 21;
  localparam int RT_HI = 20;
  localparam int RT_LO = 16;
  localparam int RD_HI = 15;
  localparam int RD_LO = 11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  typedef struct packed {
    logic [5:0] op;
    logic [5:0] fn;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] wa;
    logic       we;
    logic       use_imm;
    logic       ill;
  } dec_t;

  function automatic dec_t decode(input logic [31:0] ins);
    dec_t d;
    d.op      = ins[31:26];
    d.fn      = '0;
    d.rs      = ins[RS_HI:RS_LO];
    d.rt      = ins[RT_HI:RT_LO];
    d.wa      = ins[RT_HI:RT_LO];
    d.we      = 1'b0;
    d.use_imm = 1'b0;
    d.ill     = 1'b0;
    unique case (1'b1)
      d.op == OP_RTYPE: begin
        d.fn = ins[5:0];
        d.wa = ins[RD_HI:RD_LO];
        d.we = 1'b1;
      end
      d.op == OP_ADDI: begin
        d.we      = 1'b1;
        d.use_imm = 1'b1;
      end
      d.op == OP_LW,
      d.op == OP_SW:  d.use_imm = 1'b1;
      d.op == OP_BEQ: d.we = 1'b0;
      default:        d.ill = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/alu_operand_stage_if.sv
// Instruction issue handshake and completion report
// between an instruction source and the operand stage.
interface alu_operand_stage_if #(
  parameter int DW = 32
);
  logic          instr_valid;
  logic [31:0]   instr;
  logic          instr_ready;
  logic          done;
  logic [DW-1:0] res_data;
  logic          res_zero;
  logic          illegal;

  modport master (
    output instr_valid, instr,
    input  instr_ready, done, res_data,
    input  res_zero, illegal
  );

  modport slave (
    input  instr_valid, instr,
    output instr_ready, done, res_data,
    output res_zero, illegal
  );
endinterface

// File: rtl/alu_operand_stage_reg_file.sv
// 2^RAW x DW register file: two async reads, debug read,
// one sync write, sync clear, register 0 fixed at zero.
module reg_file #(
  parameter int DW  = 32,
  parameter int RAW = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [RAW-1:0] ra1,
  input  logic [RAW-1:0] ra2,
  output logic [DW-1:0]  rd1,
  output logic [DW-1:0]  rd2,
  input  logic           we,
  input  logic [RAW-1:0] wa,
  input  logic [DW-1:0]  wd,
  input  logic [RAW-1:0] dbg_addr,
  output logic [DW-1:0]  dbg_data
);
  logic [DW-1:0] mem [2**RAW];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2**RAW; i++)
        mem[i] <= '0;
    end else if (we && wa != '0) begin
      mem[wa] <= wd;
    end
  end

  assign rd1      = (ra1 == '0) ? '0 : mem[ra1];
  assign rd2      = (ra2 == '0) ? '0 : mem[ra2];
  assign dbg_data = (dbg_addr == '0) ? '0 : mem[dbg_addr];
endmodule

// File: rtl/alu_operand_stage.sv
// Multicycle operand fetch / writeback stage feeding a
// combinational ALU: IDLE -> EXEC -> WB, one instr per 3 cycles.
module alu_operand_stage
  import alu_stage_pkg::*;
#(
  parameter int DW  = 32,
  parameter int RAW = 5
) (
  input  logic             clk,
  input  logic             rst,
  alu_operand_stage_if.slave bus,
  output logic [5:0]       opcode,
  output logic [5:0]       func_field,
  output logic [DW-1:0]    A,
  output logic [DW-1:0]    B,
  input  logic [DW-1:0]    alu_result,
  input  logic             alu_zero,
  input  logic [RAW-1:0]   dbg_addr,
  output logic [DW-1:0]    dbg_data
);
  state_t        state_q, state_d;
  dec_t          dec;
  logic          ready, done, accept;
  logic [RAW-1:0] wa_q;
  logic          we_q, ill_q;
  logic [DW-1:0] res_data_q;
  logic          res_zero_q;
  logic [DW-1:0] rd1, rd2, imm;

  assign dec    = decode(bus.instr);
  assign imm    = {{(DW-16){bus.instr[15]}}, bus.instr[15:0]};
  assign accept = bus.instr_valid && ready;

  reg_file #(.DW(DW), .RAW(RAW)) u_rf (
    .clk      (clk),
    .rst      (rst),
    .ra1      (RAW'(dec.rs)),
    .ra2      (RAW'(dec.rt)),
    .rd1      (rd1),
    .rd2      (rd2),
    .we       (state_q == WB && we_q),
    .wa       (wa_q),
    .wd       (res_data_q),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (bus.instr_valid) state_d = EXEC;
      end
      EXEC: state_d = WB;
      // a reset landing in WB aborts: no completion pulse
      WB: begin
        done    = !rst;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      opcode     <= '0;
      func_field <= '0;
      A          <= '0;
      B          <= '0;
      wa_q       <= '0;
      we_q       <= 1'b0;
      ill_q      <= 1'b0;
      res_data_q <= '0;
      res_zero_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        opcode     <= dec.op;
        func_field <= dec.fn;
        A          <= rd1;
        B          <= dec.use_imm ? imm : rd2;
        wa_q       <= RAW'(dec.wa);
        we_q       <= dec.we;
        ill_q      <= dec.ill;
      end
      if (state_q == EXEC) begin
        res_data_q <= alu_result;
        res_zero_q <= alu_zero;
      end
    end
  end

  assign bus.instr_ready = ready;
  assign bus.done        = done;
  assign bus.res_data    = res_data_q;
  assign bus.res_zero    = res_zero_q;
  assign bus.illegal     = done & ill_q;
endmodule

// File: tb/tb_alu_operand_stage.sv
// Bench for alu_operand_stage with a behavioural ALU and a
// register-file reference model.
module tb_alu_operand_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  opcode, func_field;
  logic [31:0] A, B, alu_result, dbg_data;
  logic        alu_zero;
  logic [4:0]  dbg_addr;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_operand_stage_if #(.DW(32)) bus ();

  alu_operand_stage #(.DW(32), .RAW(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .opcode     (opcode),
    .func_field (func_field),
    .A          (A),
    .B          (B),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data)
  );

  // ALU top level stand-in
  always_comb begin
    alu_result = A + B;
    if (opcode == 6'h00) begin
      case (func_field)
        6'h20:   alu_result = A + B;
        6'h22:   alu_result = A - B;
        6'h24:   alu_result = A & B;
        6'h25:   alu_result = A | B;
        6'h2A:   alu_result = ($signed(A) < $signed(B)) ? 32'd1 : 32'd0;
        default: alu_result = '0;
      endcase
    end else if (opcode == 6'h04) begin
      alu_result = A - B;
    end
    alu_zero = (alu_result == '0);
  end

  logic [31:0] rf_m   [32];
  logic [31:0] rf_obs [32];

  typedef struct {
    logic [31:0] a, b, res;
    logic        zero, ill, we;
    int          wa;
  } exp_t;

  typedef struct {
    logic [5:0]  op, fn;
    logic [31:0] a, b, res;
    logic        zero, ill;
    logic        rdy_ex, done_ex, rdy_wb, done_wb, rdy_id, done_id;
    bit          tmo;
  } obs_t;

  function automatic exp_t model(input logic [31:0] ins);
    exp_t e;
    logic [5:0] op;
    op    = ins[31:26];
    e.a   = rf_m[ins[25:21]];
    e.b   = (op == 6'h08 || op == 6'h23 || op == 6'h2B) ?
            {{16{ins[15]}}, ins[15:0]} : rf_m[ins[20:16]];
    e.ill = !(op inside {6'h00, 6'h08, 6'h23, 6'h2B, 6'h04});
    e.we  = 1'b0;
    e.wa  = 0;
    e.res = e.a + e.b;
    if (op == 6'h00) begin
      e.we = 1'b1;
      e.wa = int'(ins[15:11]);
      case (ins[5:0])
        6'h20:   e.res = e.a + e.b;
        6'h22:   e.res = e.a - e.b;
        6'h24:   e.res = e.a & e.b;
        6'h25:   e.res = e.a | e.b;
        6'h2A:   e.res = ($signed(e.a) < $signed(e.b)) ? 1 : 0;
        default: e.res = 0;
      endcase
    end else if (op == 6'h08) begin
      e.we = 1'b1;
      e.wa = int'(ins[20:16]);
    end else if (op == 6'h04) begin
      e.res = e.a - e.b;
    end
    e.zero = (e.res == 0);
    return e;
  endfunction

  function automatic void commit(input exp_t e);
    if (e.we && e.wa != 0) rf_m[e.wa] = e.res;
  endfunction

  // entered at a negedge with the stage idle; leaves at the
  // negedge of the cycle after WB
  task automatic issue(input logic [31:0] ins, output obs_t o);
    int n = 0;
    o.tmo = 0;
    bus.instr = ins;
    bus.instr_valid = 1'b1;
    while (!bus.instr_ready && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (!bus.instr_ready) o.tmo = 1;
    @(posedge clk);
    #1 bus.instr_valid = 1'b0;
    @(negedge clk);
    o.op = opcode; o.fn = func_field; o.a = A; o.b = B;
    o.rdy_ex = bus.instr_ready; o.done_ex = bus.done;
    @(negedge clk);
    o.rdy_wb = bus.instr_ready; o.done_wb = bus.done;
    o.res = bus.res_data; o.zero = bus.res_zero;
    o.ill = bus.illegal;
    @(negedge clk);
    o.rdy_id = bus.instr_ready; o.done_id = bus.done;
  endtask

  task automatic snap_rf();
    for (int i = 0; i < 32; i++) begin
      dbg_addr = 5'(i);
      #1 rf_obs[i] = dbg_data;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.instr_valid = 1'b0;
    bus.instr = '0;
    dbg_addr = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    tests++; if (bus.instr_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b want 1", bus.instr_ready); end
    tests++; if ({opcode, func_field} !== 12'h0) begin fails++; $display("FAIL reset_op got %h want 0", {opcode, func_field}); end
    tests++; if ({A, B} !== 64'h0) begin fails++; $display("FAIL reset_ab got %h want 0", {A, B}); end
    tests++; if ({bus.res_data, bus.res_zero, bus.done, bus.illegal} !== 35'h0) begin fails++; $display("FAIL reset_res got %h want 0", {bus.res_data, bus.res_zero, bus.done, bus.illegal}); end
    for (int i = 0; i < 32; i++) rf_m[i] = '0;
    snap_rf();
    for (int i = 0; i < 32; i++) begin
      tests++; if (rf_obs[i] !== 32'h0) begin fails++; $display("FAIL reset_rf r%0d got %h want 0", i, rf_obs[i]); end
    end
  endtask

  task automatic test_addi();
    obs_t o;
    logic [31:0] prog [2];
    logic [31:0] bexp [2];
    prog[0] = 32'h20012222; bexp[0] = 32'h2222;
    prog[1] = 32'h20021111; bexp[1] = 32'h1111;
    for (int k = 0; k < 2; k++) begin
      issue(prog[k], o);
      commit(model(prog[k]));
      tests++; if (o.tmo) begin fails++; $display("FAIL addi_accept timeout"); end
      tests++; if ({o.a, o.b} !== {32'h0, bexp[k]}) begin fails++; $display("FAIL addi_ab got %h/%h want 0/%h", o.a, o.b, bexp[k]); end
      tests++; if ({o.rdy_ex, o.done_ex, o.rdy_wb, o.done_wb, o.rdy_id, o.done_id} !== 6'b000110) begin fails++; $display("FAIL addi_timing got %b want 000110", {o.rdy_ex, o.done_ex, o.rdy_wb, o.done_wb, o.rdy_id, o.done_id}); end
    end
    snap_rf();
    tests++; if (rf_obs[1] !== 32'h2222) begin fails++; $display("FAIL addi_r1 got %h want 2222", rf_obs[1]); end
    tests++; if (rf_obs[2] !== 32'h1111) begin fails++; $display("FAIL addi_r2 got %h want 1111", rf_obs[2]); end
  endtask

  task automatic test_rtype();
    obs_t o;
    issue(32'h00221820, o);
    commit(model(32'h00221820));
    tests++; if ({o.op, o.fn} !== {6'h00, 6'h20}) begin fails++; $display("FAIL add_opfn got %h/%h want 00/20", o.op, o.fn); end
    tests++; if ({o.a, o.b} !== {32'h2222, 32'h1111}) begin fails++; $display("FAIL add_ab got %h/%h want 2222/1111", o.a, o.b); end
    tests++; if (o.res !== 32'h3333 || o.done_wb !== 1'b1) begin fails++; $display("FAIL add_res got %h done %b want 3333 done 1", o.res, o.done_wb); end
    snap_rf();
    tests++; if (rf_obs[3] !== 32'h3333) begin fails++; $display("FAIL add_r3 got %h want 3333", rf_obs[3]); end
    issue(32'h00221824, o);
    commit(model(32'h00221824));
    tests++; if ({o.res, o.zero} !== {32'h0, 1'b1}) begin fails++; $display("FAIL and_res got %h z %b want 0 z 1", o.res, o.zero); end
    issue(32'h0041202A, o);
    commit(model(32'h0041202A));
    snap_rf();
    tests++; if (rf_obs[4] !== 32'h1) begin fails++; $display("FAIL slt_r4 got %h want 1", rf_obs[4]); end
  endtask

  task automatic test_beq_r0_sext();
    obs_t o;
    issue(32'h10210000, o);
    tests++; if (o.zero !== 1'b1 || o.ill !== 1'b0) begin fails++; $display("FAIL beq_zero got z %b ill %b want z 1 ill 0", o.zero, o.ill); end
    issue(32'h00220020, o);
    issue(32'h2005FFFF, o);
    commit(model(32'h2005FFFF));
    tests++; if (o.b !== 32'hFFFFFFFF) begin fails++; $display("FAIL sext_b got %h want ffffffff", o.b); end
    snap_rf();
    tests++; if (rf_obs[0] !== 32'h0) begin fails++; $display("FAIL r0 got %h want 0", rf_obs[0]); end
    tests++; if (rf_obs[5] !== 32'hFFFFFFFF) begin fails++; $display("FAIL sext_r5 got %h want ffffffff", rf_obs[5]); end
    for (int i = 0; i < 32; i++) begin
      tests++; if (rf_obs[i] !== rf_m[i]) begin fails++; $display("FAIL beq_rf r%0d got %h want %h", i, rf_obs[i], rf_m[i]); end
    end
  endtask

  task automatic test_illegal();
    obs_t o;
    exp_t e;
    e = model(32'hFC221800);
    issue(32'hFC221800, o);
    tests++; if ({o.done_wb, o.ill} !== 2'b11) begin fails++; $display("FAIL illegal_flag got %b want 11", {o.done_wb, o.ill}); end
    tests++; if (o.b !== 32'h1111 || o.res !== e.res) begin fails++; $display("FAIL illegal_b got %h res %h want 1111 res %h", o.b, o.res, e.res); end
    tests++; if (o.done_id !== 1'b0) begin fails++; $display("FAIL illegal_pulse got done %b want 0", o.done_id); end
    snap_rf();
    for (int i = 0; i < 32; i++) begin
      tests++; if (rf_obs[i] !== rf_m[i]) begin fails++; $display("FAIL illegal_rf r%0d got %h want %h", i, rf_obs[i], rf_m[i]); end
    end
  endtask

  task automatic test_reset_abort();
    bus.instr = 32'h00223020;
    bus.instr_valid = 1'b1;
    @(posedge clk);
    #1 bus.instr_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    tests++; if ({bus.done, bus.illegal} !== 2'b00) begin fails++; $display("FAIL abort_done got %b want 00", {bus.done, bus.illegal}); end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    tests++; if ({opcode, func_field, A, B} !== 76'h0) begin fails++; $display("FAIL abort_alu got %h want 0", {opcode, func_field, A, B}); end
    tests++; if ({bus.res_data, bus.res_zero, bus.done, bus.illegal} !== 35'h0) begin fails++; $display("FAIL abort_res got %h want 0", {bus.res_data, bus.res_zero, bus.done, bus.illegal}); end
    tests++; if (bus.instr_ready !== 1'b1) begin fails++; $display("FAIL abort_ready got %b want 1", bus.instr_ready); end
    for (int i = 0; i < 32; i++) rf_m[i] = '0;
    snap_rf();
    tests++; if (rf_obs[6] !== 32'h0) begin fails++; $display("FAIL abort_r6 got %h want 0", rf_obs[6]); end
    tests++; if (rf_obs[1] !== 32'h0) begin fails++; $display("FAIL abort_r1 got %h want 0", rf_obs[1]); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] seq [5];
    int acc[$];
    logic rdy_log [24];
    int idx = 0;
    for (int k = 0; k < 5; k++)
      seq[k] = {6'h08, 5'd0, 5'(10 + k), 16'(16'h0101 * (k + 1))};
    bus.instr = seq[0];
    bus.instr_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      bit took;
      rdy_log[c] = bus.instr_ready;
      took = bus.instr_ready && bus.instr_valid;
      if (took) acc.push_back(c);
      @(posedge clk);
      #1;
      if (took) begin
        commit(model(seq[idx]));
        idx++;
        if (idx < 5) bus.instr = seq[idx];
        else bus.instr_valid = 1'b0;
      end
      @(negedge clk);
    end
    tests++; if (acc.size() != 5) begin fails++; $display("FAIL b2b_count got %0d want 5", acc.size()); end
    for (int k = 0; k + 1 < acc.size(); k++) begin
      tests++; if (acc[k+1] - acc[k] != 3) begin fails++; $display("FAIL b2b_gap%0d got %0d want 3", k, acc[k+1] - acc[k]); end
      tests++; if ({rdy_log[acc[k]+1], rdy_log[acc[k]+2]} !== 2'b00) begin fails++; $display("FAIL b2b_busy%0d got %b want 00", k, {rdy_log[acc[k]+1], rdy_log[acc[k]+2]}); end
    end
    snap_rf();
    for (int k = 10; k < 15; k++) begin
      tests++; if (rf_obs[k] !== rf_m[k]) begin fails++; $display("FAIL b2b_r%0d got %h want %h", k, rf_obs[k], rf_m[k]); end
    end
  endtask

  task automatic test_random();
    obs_t o;
    exp_t e;
    logic [5:0] fns [5];
    logic [5:0] op;
    logic [31:0] ins;
    fns[0] = 6'h20; fns[1] = 6'h22; fns[2] = 6'h24;
    fns[3] = 6'h25; fns[4] = 6'h2A;
    for (int n = 0; n < 48; n++) begin
      int kind;
      kind = (n < 10) ? 1 : int'($urandom_range(0, 5));
      ins = $urandom();
      case (kind)
        0, 2, 3: ins = {6'h00, ins[25:6], fns[$urandom_range(0, 4)]};
        1:       ins = {6'h08, ins[25:0]};
        4:       ins = {6'h04, ins[25:0]};
        default: begin
          op = 6'($urandom_range(0, 63));
          while (op inside {6'h00, 6'h08, 6'h23, 6'h2B, 6'h04})
            op = 6'($urandom_range(0, 63));
          ins = {op, ins[25:0]};
        end
      endcase
      e = model(ins);
      issue(ins, o);
      commit(e);
      tests++; if (o.tmo) begin fails++; $display("FAIL rnd_accept %h timeout", ins); end
      tests++; if ({o.a, o.b} !== {e.a, e.b}) begin fails++; $display("FAIL rnd_ab %h got %h/%h want %h/%h", ins, o.a, o.b, e.a, e.b); end
      tests++; if ({o.res, o.zero, o.ill} !== {e.res, e.zero, e.ill}) begin fails++; $display("FAIL rnd_res %h got %h %b %b want %h %b %b", ins, o.res, o.zero, o.ill, e.res, e.zero, e.ill); end
      tests++; if ({o.done_ex, o.done_wb, o.rdy_id} !== 3'b011) begin fails++; $display("FAIL rnd_timing %h got %b want 011", ins, {o.done_ex, o.done_wb, o.rdy_id}); end
    end
    snap_rf();
    for (int i = 0; i < 32; i++) begin
      tests++; if (rf_obs[i] !== rf_m[i]) begin fails++; $display("FAIL rnd_rf r%0d got %h want %h", i, rf_obs[i], rf_m[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_rtype();
    test_beq_r0_sext();
    test_illegal();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
